// File: rtl/pcie_tx_arb_pkg.sv
// Shared types and constants for the PCIe transmit arbiter.
package pcie_tx_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_CFG   = 2'd3
  } arb_state_e;

  localparam int BUF_AV_MIN_DEFAULT = 2;
  localparam int TUSER_WIDTH        = 4;

endpackage

// File: rtl/pcie_rr_pick.sv
// Combinational round-robin pick: first valid requester after last_grant, wrapping.
module pcie_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any_valid
);

  int cand;

  // Scan from farthest to nearest so the nearest valid requester wins.
  always_comb begin
    idx       = '0;
    any_valid = |valid;
    cand      = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = (int'(last_grant) + k) % NUM_REQ;
      if (valid[cand[IDX_W-1:0]]) begin
        idx = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/pcie_tx_arbiter.sv
// Packet-level round-robin arbiter for the PCIe core transmit AXI-stream port.
// Optional config-TLP holding (CFG state) is enabled by PCIE_TX_ARB_CFG_HOLD_EN.
//
// state | meaning
// IDLE  | between packets; grant decision (or cfg grant) made here
// XFER  | granted requester streams to the core through the mux
// DRAIN | link lost mid-packet; remaining beats swallowed up to tlast
// CFG   | core owns the port for config TLPs (only with holding enabled)
module pcie_tx_arbiter
  import pcie_tx_arb_pkg::*;
#(
  parameter int PCIE_DATA_WIDTH = 64,
  parameter int PCIE_KEEP_WIDTH = PCIE_DATA_WIDTH >> 3,
  parameter int NUM_REQ         = 4,
  parameter int BUF_AV_MIN      = BUF_AV_MIN_DEFAULT
) (
  input  logic                               pcie_clk_in,
  input  logic                               pcie_reset_out,
  input  logic                               pcie_link_up,
  input  logic [NUM_REQ*PCIE_DATA_WIDTH-1:0] req_tdata,
  input  logic [NUM_REQ*PCIE_KEEP_WIDTH-1:0] req_tkeep,
  input  logic [NUM_REQ*TUSER_WIDTH-1:0]     req_tuser,
  input  logic [NUM_REQ-1:0]                 req_tlast,
  input  logic [NUM_REQ-1:0]                 req_tvalid,
  output logic [NUM_REQ-1:0]                 req_tready,
  output logic [PCIE_DATA_WIDTH-1:0]         s_axis_tx_tdata,
  output logic [PCIE_KEEP_WIDTH-1:0]         s_axis_tx_tkeep,
  output logic [TUSER_WIDTH-1:0]             s_axis_tx_tuser,
  output logic                               s_axis_tx_tlast,
  output logic                               s_axis_tx_tvalid,
  input  logic                               s_axis_tx_tready,
  input  logic [5:0]                         tx_buf_av,
  input  logic                               tx_terr_drop,
  input  logic                               tx_cfg_req,
  output logic                               tx_cfg_gnt,
  output logic [$clog2(NUM_REQ)-1:0]         grant_id,
  output logic [15:0]                        err_drop_cnt
);

  localparam int         IDX_W     = $clog2(NUM_REQ);
  localparam logic [5:0] BUF_MIN_V = 6'(BUF_AV_MIN);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [15:0]      err_cnt_q, err_cnt_d;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             passing, draining;
  logic             g_valid, g_last;

  pcie_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid      (req_tvalid),
    .last_grant (last_q),
    .idx        (pick_idx),
    .any_valid  (pick_any)
  );

  assign g_valid = req_tvalid[grant_q];
  assign g_last  = req_tlast[grant_q];

  // Link loss is acted on in the same cycle it is seen, not one cycle later.
  assign passing  = (state_q == ST_XFER) && pcie_link_up;
  assign draining = (state_q == ST_DRAIN) || ((state_q == ST_XFER) && !pcie_link_up);

  always_comb begin
    s_axis_tx_tdata  = '0;
    s_axis_tx_tkeep  = '0;
    s_axis_tx_tuser  = '0;
    s_axis_tx_tlast  = 1'b0;
    s_axis_tx_tvalid = 1'b0;
    req_tready       = '0;
    if (passing) begin
      s_axis_tx_tdata     = req_tdata[grant_q*PCIE_DATA_WIDTH +: PCIE_DATA_WIDTH];
      s_axis_tx_tkeep     = req_tkeep[grant_q*PCIE_KEEP_WIDTH +: PCIE_KEEP_WIDTH];
      s_axis_tx_tuser     = req_tuser[grant_q*TUSER_WIDTH +: TUSER_WIDTH];
      s_axis_tx_tlast     = g_last;
      s_axis_tx_tvalid    = g_valid;
      req_tready[grant_q] = s_axis_tx_tready;
    end else if (draining) begin
      req_tready[grant_q] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
`ifdef PCIE_TX_ARB_CFG_HOLD_EN
        if (tx_cfg_req) begin
          state_d = ST_CFG;
        end else
`endif
        if (pcie_link_up && (tx_buf_av >= BUF_MIN_V) && pick_any) begin
          grant_d = pick_idx;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (!pcie_link_up) begin
          if (g_valid && g_last) begin
            state_d = ST_IDLE;
            last_d  = grant_q;
          end else begin
            state_d = ST_DRAIN;
          end
        end else if (g_valid && s_axis_tx_tready && g_last) begin
          state_d = ST_IDLE;
          last_d  = grant_q;
        end
      end
      ST_DRAIN: begin
        if (g_valid && g_last) begin
          state_d = ST_IDLE;
          last_d  = grant_q;
        end
      end
      ST_CFG: begin
`ifdef PCIE_TX_ARB_CFG_HOLD_EN
        if (!tx_cfg_req) state_d = ST_IDLE;
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (tx_terr_drop && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge pcie_clk_in or posedge pcie_reset_out) begin
    if (pcie_reset_out) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      last_q    <= IDX_W'(NUM_REQ - 1);
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign grant_id     = grant_q;
  assign err_drop_cnt = err_cnt_q;

`ifdef PCIE_TX_ARB_CFG_HOLD_EN
  assign tx_cfg_gnt = (state_q == ST_CFG);
`else
  // Core interleaves config TLPs freely, so the request is not looked at.
  logic unused_cfg_req;
  assign unused_cfg_req = tx_cfg_req;
  assign tx_cfg_gnt     = 1'b1;
`endif

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// Directed, table-driven bench for pcie_tx_arbiter with simple requester/core models.
module tb_pcie_tx_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         link = 1'b1;
  logic [255:0] req_tdata;
  logic [31:0]  req_tkeep;
  logic [15:0]  req_tuser;
  logic [3:0]   req_tlast, req_tvalid, req_tready;
  logic [63:0]  s_tdata;
  logic [7:0]   s_tkeep;
  logic [3:0]   s_tuser;
  logic         s_tlast, s_tvalid;
  logic         core_rdy = 1'b1;
  logic [5:0]   buf_av = 6'd20;
  logic         terr = 1'b0;
  logic         cfg_req = 1'b0;
  logic         cfg_gnt;
  logic [1:0]   gid;
  logic [15:0]  err_cnt;

  logic [3:0]   req_v = 4'b0000;
  int           len[4] = '{3, 3, 3, 3};
  int           beat[4] = '{0, 0, 0, 0};
  logic [7:0]   acc[64];
  int           acc_n = 0;
  int           hs_n = 0;
  int           checks = 0;
  int           failures = 0;

  always #5 clk = ~clk;

  pcie_tx_arbiter dut (
    .pcie_clk_in      (clk),
    .pcie_reset_out   (rst),
    .pcie_link_up     (link),
    .req_tdata        (req_tdata),
    .req_tkeep        (req_tkeep),
    .req_tuser        (req_tuser),
    .req_tlast        (req_tlast),
    .req_tvalid       (req_tvalid),
    .req_tready       (req_tready),
    .s_axis_tx_tdata  (s_tdata),
    .s_axis_tx_tkeep  (s_tkeep),
    .s_axis_tx_tuser  (s_tuser),
    .s_axis_tx_tlast  (s_tlast),
    .s_axis_tx_tvalid (s_tvalid),
    .s_axis_tx_tready (core_rdy),
    .tx_buf_av        (buf_av),
    .tx_terr_drop     (terr),
    .tx_cfg_req       (cfg_req),
    .tx_cfg_gnt       (cfg_gnt),
    .grant_id         (gid),
    .err_drop_cnt     (err_cnt)
  );

  // Requester i presents data {i, beat} and raises tlast on beat len[i]-1.
  always_comb begin
    req_tdata  = '0;
    req_tkeep  = '0;
    req_tuser  = '0;
    req_tlast  = '0;
    req_tvalid = req_v;
    for (int i = 0; i < 4; i++) begin
      req_tdata[i*64 +: 64] = {56'h0, 4'(i), 4'(beat[i])};
      req_tkeep[i*8 +: 8]   = 8'hFF;
      req_tuser[i*4 +: 4]   = 4'(i);
      req_tlast[i]          = (beat[i] == len[i] - 1);
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) beat[i] <= 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (req_tvalid[i] && req_tready[i]) begin
          beat[i] <= req_tlast[i] ? 0 : beat[i] + 1;
          hs_n    <= hs_n + 1;
        end
      end
      if (s_tvalid && core_rdy) begin
        acc[acc_n % 64] <= s_tdata[7:0];
        acc_n           <= acc_n + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] rdy;
    logic       vld;
    logic       lst;
    logic [1:0] gid;
    logic [7:0] dat;
  } vec_t;

  vec_t tbl[21];

  initial begin
    int base;
    int hbase;

    tbl[0]  = '{4'b0000, 1'b0, 1'b0, 2'd0, 8'h00};
    tbl[1]  = '{4'b0001, 1'b1, 1'b0, 2'd0, 8'h00};
    tbl[2]  = '{4'b0001, 1'b1, 1'b0, 2'd0, 8'h01};
    tbl[3]  = '{4'b0001, 1'b1, 1'b1, 2'd0, 8'h02};
    tbl[4]  = '{4'b0000, 1'b0, 1'b0, 2'd0, 8'h00};
    tbl[5]  = '{4'b0010, 1'b1, 1'b0, 2'd1, 8'h10};
    tbl[6]  = '{4'b0010, 1'b1, 1'b0, 2'd1, 8'h11};
    tbl[7]  = '{4'b0010, 1'b1, 1'b1, 2'd1, 8'h12};
    tbl[8]  = '{4'b0000, 1'b0, 1'b0, 2'd1, 8'h00};
    tbl[9]  = '{4'b0100, 1'b1, 1'b0, 2'd2, 8'h20};
    tbl[10] = '{4'b0100, 1'b1, 1'b0, 2'd2, 8'h21};
    tbl[11] = '{4'b0100, 1'b1, 1'b1, 2'd2, 8'h22};
    tbl[12] = '{4'b0000, 1'b0, 1'b0, 2'd2, 8'h00};
    tbl[13] = '{4'b1000, 1'b1, 1'b0, 2'd3, 8'h30};
    tbl[14] = '{4'b1000, 1'b1, 1'b0, 2'd3, 8'h31};
    tbl[15] = '{4'b1000, 1'b1, 1'b1, 2'd3, 8'h32};
    tbl[16] = '{4'b0000, 1'b0, 1'b0, 2'd3, 8'h00};
    tbl[17] = '{4'b0001, 1'b1, 1'b0, 2'd0, 8'h00};
    tbl[18] = '{4'b0001, 1'b1, 1'b0, 2'd0, 8'h01};
    tbl[19] = '{4'b0001, 1'b1, 1'b1, 2'd0, 8'h02};
    tbl[20] = '{4'b0000, 1'b0, 1'b0, 2'd0, 8'h00};

    // Reset values while reset is held
    req_v = 4'b1111;
    #1;
    chk("rst_tvalid", 64'(s_tvalid), 64'd0);
    chk("rst_tready", 64'(req_tready), 64'd0);
    chk("rst_gid", 64'(gid), 64'd0);
    chk("rst_tdata", s_tdata, 64'd0);
    chk("rst_tlast", 64'(s_tlast), 64'd0);
    chk("rst_err", 64'(err_cnt), 64'd0);

    // Round-robin over four 3-beat requesters, one bubble between packets
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 21; i++) begin
      if (i > 0) cyc();
      chk($sformatf("rr%0d_tready", i), 64'(req_tready), 64'(tbl[i].rdy));
      chk($sformatf("rr%0d_tvalid", i), 64'(s_tvalid), 64'(tbl[i].vld));
      chk($sformatf("rr%0d_tlast", i), 64'(s_tlast), 64'(tbl[i].lst));
      chk($sformatf("rr%0d_gid", i), 64'(gid), 64'(tbl[i].gid));
      chk($sformatf("rr%0d_tdata", i), s_tdata, {56'h0, tbl[i].dat});
    end
    req_v = 4'b0000;

    // tx_buf_av below minimum blocks the grant
    cyc();
    req_v  = 4'b0100;
    buf_av = 6'd1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bufav_low_tvalid", 64'(s_tvalid), 64'd0);
      chk("bufav_low_tready", 64'(req_tready), 64'd0);
    end
    @(negedge clk);
    buf_av = 6'd5;
    #1;
    chk("bufav_ok_idle", 64'(s_tvalid), 64'd0);
    cyc();
    chk("bufav_first_vld", 64'(s_tvalid), 64'd1);
    chk("bufav_first_gid", 64'(gid), 64'd2);
    chk("bufav_first_dat", s_tdata, 64'h20);
    chk("bufav_first_rdy", 64'(req_tready), 64'b0100);
    cyc();
    cyc();
    chk("bufav_last", 64'(s_tlast), 64'd1);
    cyc();
    chk("bufav_end_idle", 64'(s_tvalid), 64'd0);
    req_v = 4'b0000;

    // Core backpressure for 4 cycles mid-packet
    base   = acc_n;
    len[1] = 4;
    cyc();
    req_v = 4'b0010;
    cyc();
    chk("bp_beat0", s_tdata, 64'h10);
    @(negedge clk);
    core_rdy = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc();
      chk("bp_stall_rdy", 64'(req_tready), 64'd0);
      chk("bp_stall_vld", 64'(s_tvalid), 64'd1);
      chk("bp_stall_dat", s_tdata, 64'h11);
    end
    @(negedge clk);
    core_rdy = 1'b1;
    #1;
    chk("bp_resume_dat", s_tdata, 64'h11);
    chk("bp_resume_rdy", 64'(req_tready), 64'b0010);
    cyc();
    cyc();
    chk("bp_last", 64'(s_tlast), 64'd1);
    cyc();
    req_v = 4'b0000;
    chk("bp_count", 64'(acc_n - base), 64'd4);
    for (int k = 0; k < 4; k++) chk($sformatf("bp_data%0d", k), 64'(acc[(base + k) % 64]), 64'(8'h10 + k));

    // Link loss on the third beat of a 5-beat packet
    base   = acc_n;
    hbase  = hs_n;
    len[3] = 5;
    cyc();
    req_v = 4'b1000;
    cyc();
    chk("link_beat0", s_tdata, 64'h30);
    cyc();
    chk("link_beat1", s_tdata, 64'h31);
    @(negedge clk);
    link = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) cyc();
      chk("drain_tvalid", 64'(s_tvalid), 64'd0);
      chk("drain_tready", 64'(req_tready), 64'b1000);
    end
    cyc();
    chk("drain_idle_rdy", 64'(req_tready), 64'd0);
    chk("drain_idle_vld", 64'(s_tvalid), 64'd0);
    req_v = 4'b0000;
    link  = 1'b1;
    chk("drain_core_beats", 64'(acc_n - base), 64'd2);
    chk("drain_req_beats", 64'(hs_n - hbase), 64'd5);

    // Asynchronous reset mid-packet
    len[2] = 4;
    cyc();
    req_v = 4'b0100;
    cyc();
    cyc();
    chk("mid_pre_gid", 64'(gid), 64'd2);
    chk("mid_pre_vld", 64'(s_tvalid), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_vld", 64'(s_tvalid), 64'd0);
    chk("mid_rst_rdy", 64'(req_tready), 64'd0);
    chk("mid_rst_gid", 64'(gid), 64'd0);
    chk("mid_rst_dat", s_tdata, 64'd0);
    @(negedge clk);
    req_v = 4'b0000;
    rst   = 1'b0;

`ifdef PCIE_TX_ARB_CFG_HOLD_EN
    // Config request mid-packet is held until the packet boundary
    len[0] = 4;
    cyc();
    req_v = 4'b0001;
    cyc();
    chk("cfg_b1_gnt", 64'(cfg_gnt), 64'd0);
    cfg_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("cfg_pkt_gnt", 64'(cfg_gnt), 64'd0);
      chk("cfg_pkt_vld", 64'(s_tvalid), 64'd1);
    end
    cyc();
    chk("cfg_idle_gnt", 64'(cfg_gnt), 64'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("cfg_hold_gnt", 64'(cfg_gnt), 64'd1);
      chk("cfg_hold_rdy", 64'(req_tready), 64'd0);
      chk("cfg_hold_vld", 64'(s_tvalid), 64'd0);
    end
    cfg_req = 1'b0;
    cyc();
    chk("cfg_release_gnt", 64'(cfg_gnt), 64'd0);
    req_v = 4'b0000;
    cyc();
    chk("cfg_after_vld", 64'(s_tvalid), 64'd0);
`else
    // Without holding, the grant is constant regardless of traffic or request
    len[0] = 2;
    cyc();
    chk("gnt_tied_idle", 64'(cfg_gnt), 64'd1);
    req_v   = 4'b0001;
    cfg_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("gnt_tied", 64'(cfg_gnt), 64'd1);
    end
    req_v   = 4'b0000;
    cfg_req = 1'b0;
    cyc();
    chk("gnt_tied_end", 64'(cfg_gnt), 64'd1);
`endif

    // Drop counter: three pulses, then drive to saturation
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      terr = 1'b1;
      @(negedge clk);
      terr = 1'b0;
    end
    #1;
    chk("err_cnt3", 64'(err_cnt), 64'd3);
    @(negedge clk);
    terr = 1'b1;
    repeat (65531) @(negedge clk);
    terr = 1'b0;
    #1;
    chk("err_cnt_fffe", 64'(err_cnt), 64'hFFFE);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      terr = 1'b1;
      @(negedge clk);
      terr = 1'b0;
    end
    #1;
    chk("err_cnt_sat", 64'(err_cnt), 64'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
